// File: rtl/ecc_pkg.sv
// Shared definitions for the streaming SECDED codec: mode type and the
// Hamming position helpers used both at elaboration time and in logic.
package ecc_pkg;

   typedef enum logic {
      ECC_ENC = 1'b0,
      ECC_CHK = 1'b1
   } ecc_mode_e;

   // Smallest r such that 2^r >= data_bits + r + 1.
   function automatic int ecc_r(input int data_bits);
      int r;
      r = 0;
      for (int k = 1; k < 31; k++) begin
         if (r == 0 && (1 << k) >= data_bits + k + 1) begin
            r = k;
         end
      end
      return r;
   endfunction

   // Data index -> Hamming position. Walking the powers of two in order and
   // bumping past each one that is not above the running position lands on
   // the i-th non-power-of-two position (0->3, 1->5, 2->6, 3->7, 4->9, ...).
   function automatic int ecc_pos(input int i);
      int p;
      p = i + 1;
      for (int k = 0; k < 31; k++) begin
         if ((1 << k) <= p) begin
            p = p + 1;
         end
      end
      return p;
   endfunction

   // Hamming position -> data index: subtract the check-bit positions below it.
   function automatic int ecc_idx(input int pos);
      int n_pow;
      n_pow = 0;
      for (int k = 0; k < 31; k++) begin
         if ((1 << k) <= pos) begin
            n_pow = n_pow + 1;
         end
      end
      return pos - 1 - n_pow;
   endfunction

endpackage

// File: rtl/ecc_syndrome_classify.sv
// Combinational SECDED decision: turns syndrome and overall-parity mismatch
// into single/double error flags and, for data-bit errors, the bit index.
module ecc_syndrome_classify
   import ecc_pkg::*;
#(
   parameter int DATA_BITS = 128,
   parameter int R         = 8,
   parameter int POS_W     = 7
) (
   input  logic [R-1:0]     syn,
   input  logic             mismatch,
   output logic             err_single,
   output logic             err_double,
   output logic             err_in_data,
   output logic [POS_W-1:0] err_pos
);

   // Highest Hamming position that actually carries a data bit.
   localparam int MAX_POS = ecc_pos(DATA_BITS - 1);

   int   syn_int;
   logic syn_pow2;

   // Classify the (syndrome, mismatch) pair; flags are mutually exclusive.
   always_comb begin
      err_single  = 1'b0;
      err_double  = 1'b0;
      err_in_data = 1'b0;
      err_pos     = '0;
      syn_int     = int'(syn);
      syn_pow2    = (syn != '0) && ((syn & (syn - R'(1))) == '0);
      if (mismatch) begin
         if (syn == '0 || syn_pow2) begin
            // Flip of P itself or of one H bit: data is intact.
            err_single = 1'b1;
         end else if (syn_int <= MAX_POS) begin
            err_single  = 1'b1;
            err_in_data = 1'b1;
            err_pos     = POS_W'(ecc_idx(syn_int));
         end else begin
            // Odd parity but syndrome points past the code: not a single flip.
            err_double = 1'b1;
         end
      end else if (syn != '0) begin
         err_double = 1'b1;
      end
   end

endmodule

// File: rtl/ecc_stream_codec.sv
// Streaming SECDED codec: accumulates Hamming check bits and data parity over
// a block of WORDS words, then returns the block code (encode) or the error
// classification against a supplied code (check).
module ecc_stream_codec
   import ecc_pkg::*;
#(
   parameter  int WORD_W    = 16,
   parameter  int WORDS     = 8,
   localparam int DATA_BITS = WORD_W * WORDS,
   localparam int R         = ecc_r(DATA_BITS),
   localparam int CODE_W    = R + 1,
   localparam int POS_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_mode,
   input  logic [CODE_W-1:0] in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_code,
   output logic              out_mode,
   output logic              out_err_single,
   output logic              out_err_double,
   output logic              out_err_in_data,
   output logic [POS_W-1:0]  out_err_pos
);

   localparam int               CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [R-1:0]     h_acc_reg;
   logic             d_acc_reg;
   ecc_mode_e        mode_reg;

   logic [R-1:0]     word_h [WORDS];
   logic [R-1:0]     h_next;
   logic             d_next;
   ecc_mode_e        blk_mode;
   logic [R-1:0]     syn;
   logic             mis;
   logic             last_word;
   logic             accept;

   logic             cls_single;
   logic             cls_double;
   logic             cls_in_data;
   logic [POS_W-1:0] cls_pos;

   // H contribution of one word when it sits at block slot w: XOR of the
   // positions of its set bits. w is a constant per instance, so each slot
   // reduces to a fixed XOR network.
   function automatic logic [R-1:0] word_contrib(input logic [WORD_W-1:0] d, input int w);
      logic [R-1:0] acc;
      acc = '0;
      for (int b = 0; b < WORD_W; b++) begin
         if (d[b]) begin
            acc = acc ^ R'(ecc_pos(w * WORD_W + b));
         end
      end
      return acc;
   endfunction

   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
         assign word_h[gi] = word_contrib(in_data, gi);
      end
   endgenerate

   assign last_word = (cnt_reg == LAST_CNT);
   // Only the last word must wait for the pending result to drain.
   assign in_ready  = !(last_word && out_valid && !out_ready);
   assign accept    = in_valid && in_ready;

   // Next accumulator values, block mode and check-mode syndrome.
   always_comb begin
      h_next   = h_acc_reg ^ word_h[cnt_reg];
      d_next   = d_acc_reg ^ (^in_data);
      blk_mode = (cnt_reg == '0) ? ecc_mode_e'(in_mode) : mode_reg;
      syn      = h_next ^ in_code[R-1:0];
      mis      = d_next ^ (^in_code);
   end

   ecc_syndrome_classify #(
      .DATA_BITS (DATA_BITS),
      .R         (R),
      .POS_W     (POS_W)
   ) u_classify (
      .syn         (syn),
      .mismatch    (mis),
      .err_single  (cls_single),
      .err_double  (cls_double),
      .err_in_data (cls_in_data),
      .err_pos     (cls_pos)
   );

   // Word counter, accumulators and latched block mode; cleared at block end.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg   <= '0;
         h_acc_reg <= '0;
         d_acc_reg <= 1'b0;
         mode_reg  <= ECC_ENC;
      end else if (accept) begin
         if (last_word) begin
            cnt_reg   <= '0;
            h_acc_reg <= '0;
            d_acc_reg <= 1'b0;
         end else begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
            h_acc_reg <= h_next;
            d_acc_reg <= d_next;
         end
         if (cnt_reg == '0) begin
            mode_reg <= ecc_mode_e'(in_mode);
         end
      end
   end

   // Result registers: load on last-word acceptance, drop valid on consume.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid       <= 1'b0;
         out_code        <= '0;
         out_mode        <= 1'b0;
         out_err_single  <= 1'b0;
         out_err_double  <= 1'b0;
         out_err_in_data <= 1'b0;
         out_err_pos     <= '0;
      end else if (accept && last_word) begin
         out_valid <= 1'b1;
         out_code  <= {d_next ^ (^h_next), h_next};
         out_mode  <= (blk_mode == ECC_CHK);
         if (blk_mode == ECC_CHK) begin
            out_err_single  <= cls_single;
            out_err_double  <= cls_double;
            out_err_in_data <= cls_in_data;
            out_err_pos     <= cls_pos;
         end else begin
            out_err_single  <= 1'b0;
            out_err_double  <= 1'b0;
            out_err_in_data <= 1'b0;
            out_err_pos     <= '0;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ecc_stream_codec.sv
// Self-checking bench for ecc_stream_codec with a position-table reference model.
module tb_ecc_stream_codec;

   localparam int WORD_W    = 16;
   localparam int WORDS     = 8;
   localparam int DATA_BITS = WORD_W * WORDS;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        in_valid  = 1'b0;
   logic        in_mode   = 1'b0;
   logic        out_ready = 1'b1;
   logic [15:0] in_data   = '0;
   logic [8:0]  in_code   = '0;
   logic        in_ready;
   logic        out_valid;
   logic        out_mode;
   logic        out_err_single;
   logic        out_err_double;
   logic        out_err_in_data;
   logic [8:0]  out_code;
   logic [6:0]  out_err_pos;

   typedef struct {
      logic [8:0] code;
      logic       mode;
      logic       single;
      logic       dbl;
      logic       in_data;
      logic [6:0] pos;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_results = 0;
   int          pos_of [DATA_BITS];
   int          idx_of [256];
   logic [15:0] blk [WORDS];
   logic [8:0]  cur_code;
   logic        rand_rdy = 1'b0;

   always #5 clk = ~clk;

   ecc_stream_codec #(
      .WORD_W (WORD_W),
      .WORDS  (WORDS)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .in_mode         (in_mode),
      .in_code         (in_code),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_code        (out_code),
      .out_mode        (out_mode),
      .out_err_single  (out_err_single),
      .out_err_double  (out_err_double),
      .out_err_in_data (out_err_in_data),
      .out_err_pos     (out_err_pos)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Enumerate Hamming positions 1,2,3,... skipping powers of two.
   function automatic void build_tables();
      int p;
      p = 1;
      for (int i = 0; i < 256; i++) idx_of[i] = -1;
      for (int i = 0; i < DATA_BITS; i++) begin
         while ((p & (p - 1)) == 0) p++;
         pos_of[i] = p;
         idx_of[p] = i;
         p++;
      end
   endfunction

   function automatic exp_t mk_exp(input logic [8:0] code, input logic mode, input logic s,
                                   input logic d, input logic in_d, input logic [6:0] pos);
      exp_t e;
      e.code = code; e.mode = mode; e.single = s; e.dbl = d; e.in_data = in_d; e.pos = pos;
      return e;
   endfunction

   // Reference result for the block currently held in blk[].
   function automatic exp_t model(input logic mode, input logic [8:0] code_in);
      exp_t e;
      int   h, npar, s, m;
      logic pbit;
      h = 0;
      npar = 0;
      for (int w = 0; w < WORDS; w++)
         for (int b = 0; b < WORD_W; b++)
            if (blk[w][b]) begin
               h = h ^ pos_of[w * WORD_W + b];
               npar++;
            end
      pbit = ((($countones(h) + npar) % 2) != 0);
      e = mk_exp({pbit, h[7:0]}, mode, 1'b0, 1'b0, 1'b0, 7'd0);
      if (mode) begin
         s = h ^ int'(code_in[7:0]);
         m = (npar + $countones(code_in)) % 2;
         if (m == 0) e.dbl = (s != 0);
         else if (s == 0 || $countones(s) == 1) e.single = 1'b1;
         else if (idx_of[s] >= 0) begin
            e.single = 1'b1;
            e.in_data = 1'b1;
            e.pos = 7'(idx_of[s]);
         end else e.dbl = 1'b1;
      end
      return e;
   endfunction

   task automatic drive_word(input logic [15:0] d, input logic mode, input logic [8:0] code,
                             output int waits);
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = mode;
      in_code  = code;
      waits    = 0;
      @(negedge clk);
      while (!in_ready && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) check_eq("in_ready_timeout", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Mode matters only on word 0 and code only on the last word: scramble the rest.
   task automatic send_block(input logic mode, input logic [8:0] code_in, input exp_t e);
      int wt;
      exp_q.push_back(e);
      for (int w = 0; w < WORDS; w++)
         drive_word(blk[w], (w == 0) ? mode : 1'($urandom_range(0, 1)),
                    (w == WORDS - 1) ? code_in : 9'($urandom), wt);
      check_eq("valid_after_last", 32'(out_valid), 1);
   endtask

   task automatic flip_bit(input int k);
      if (k < DATA_BITS) blk[k / WORD_W][k % WORD_W] = ~blk[k / WORD_W][k % WORD_W];
      else cur_code[k - DATA_BITS] = ~cur_code[k - DATA_BITS];
   endtask

   task automatic fill_random();
      for (int w = 0; w < WORDS; w++) blk[w] = 16'($urandom);
   endtask

   task automatic fill_zero();
      for (int w = 0; w < WORDS; w++) blk[w] = '0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("queue_drained", exp_q.size(), 0);
   endtask

   // Compare every presented result against the scoreboard head; retire on handshake.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_result", 32'(out_valid), 0);
         end else begin
            check_eq("out_code", 32'(out_code), 32'(exp_q[0].code));
            check_eq("out_mode", 32'(out_mode), 32'(exp_q[0].mode));
            check_eq("err_single", 32'(out_err_single), 32'(exp_q[0].single));
            check_eq("err_double", 32'(out_err_double), 32'(exp_q[0].dbl));
            check_eq("err_in_data", 32'(out_err_in_data), 32'(exp_q[0].in_data));
            if (exp_q[0].in_data) check_eq("err_pos", 32'(out_err_pos), 32'(exp_q[0].pos));
            if (out_ready) begin
               $display("result %0d: mode=%0d code=%03h single=%0d double=%0d in_data=%0d pos=%0d",
                        n_results, out_mode, out_code, out_err_single, out_err_double,
                        out_err_in_data, out_err_pos);
               n_results++;
               exp_q.delete(0);
            end
         end
      end
   end

   // Random consumer backpressure during the mixed-traffic phase.
   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      exp_t ea, eb;
      int   wt, nf, f1, f2;
      logic md;

      build_tables();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_in_ready", 32'(in_ready), 1);
      check_eq("rst_out_code", 32'(out_code), 0);
      check_eq("rst_flags", {29'd0, out_err_single, out_err_double, out_err_in_data}, 0);
      check_eq("rst_mode_pos", {24'd0, out_mode, out_err_pos}, 0);
      rst = 1'b0;

      // Directed encode and check cases with hand-derived expectations.
      fill_zero();
      send_block(1'b0, 9'h000, mk_exp(9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0));
      blk[0] = 16'h0001;
      send_block(1'b0, 9'h000, mk_exp(9'h103, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0));
      send_block(1'b1, 9'h000, mk_exp(9'h103, 1'b1, 1'b1, 1'b0, 1'b1, 7'd0));
      send_block(1'b1, 9'h103, mk_exp(9'h103, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0));
      fill_zero();
      send_block(1'b1, 9'h100, mk_exp(9'h000, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0));
      send_block(1'b1, 9'h004, mk_exp(9'h000, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0));
      send_block(1'b1, 9'h089, mk_exp(9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0));
      blk[0] = 16'h0003;
      send_block(1'b1, 9'h000, mk_exp(9'h006, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0));
      fill_zero();
      blk[7] = 16'h8000;
      send_block(1'b1, 9'h000, mk_exp(9'h188, 1'b1, 1'b1, 1'b0, 1'b1, 7'd127));

      // Random encodes, then random checks with 0, 1 or 2 flipped bits.
      for (int t = 0; t < 8; t++) begin
         fill_random();
         send_block(1'b0, 9'h000, model(1'b0, 9'h000));
      end
      for (int t = 0; t < 16; t++) begin
         fill_random();
         ea = model(1'b0, 9'h000);
         cur_code = ea.code;
         nf = $urandom_range(0, 2);
         f1 = $urandom_range(0, DATA_BITS + 8);
         f2 = (f1 + 1 + $urandom_range(0, DATA_BITS + 7)) % (DATA_BITS + 9);
         if (nf >= 1) flip_bit(f1);
         if (nf == 2) flip_bit(f2);
         send_block(1'b1, cur_code, model(1'b1, cur_code));
      end

      // Mixed traffic under random consumer backpressure.
      rand_rdy = 1'b1;
      for (int t = 0; t < 6; t++) begin
         fill_random();
         md = 1'($urandom_range(0, 1));
         cur_code = 9'($urandom);
         send_block(md, cur_code, model(md, cur_code));
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      wait_drain();

      // Backpressure: B's last word stalls until A is consumed on the same edge.
      out_ready = 1'b0;
      fill_random();
      ea = model(1'b0, 9'h000);
      send_block(1'b0, 9'h000, ea);
      fill_random();
      eb = model(1'b0, 9'h000);
      exp_q.push_back(eb);
      for (int w = 0; w < WORDS - 1; w++) begin
         drive_word(blk[w], 1'b0, 9'h000, wt);
         check_eq("bp_no_stall", wt, 0);
      end
      in_valid = 1'b1;
      in_data  = blk[WORDS - 1];
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq("bp_stall_ready", 32'(in_ready), 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_release_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_eq("bp_valid_stays", 32'(out_valid), 1);
      @(posedge clk);
      #1;
      check_eq("valid_fall", 32'(out_valid), 0);

      // Reset mid-block with a result pending: both are discarded.
      out_ready = 1'b0;
      fill_random();
      send_block(1'b0, 9'h000, model(1'b0, 9'h000));
      fill_random();
      for (int w = 0; w < 4; w++) drive_word(blk[w], 1'b1, 9'h000, wt);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      check_eq("midrst_out_valid", 32'(out_valid), 0);
      check_eq("midrst_in_ready", 32'(in_ready), 1);
      out_ready = 1'b1;
      fill_random();
      send_block(1'b0, 9'h000, model(1'b0, 9'h000));
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
